// File: rtl/control_busqueda_pkg.sv
// Shared state encoding and default widths for the instruction-fetch controller.
package control_busqueda_pkg;

    localparam int ANCHO_PC_DEF    = 11;
    localparam int ANCHO_INSTR_DEF = 32;

    typedef enum logic [1:0] {
        INICIO    = 2'd0,
        BUSCAR    = 2'd1,
        ESPERAR   = 2'd2,
        DESCARTAR = 2'd3
    } estado_t;

endpackage

// File: rtl/control_busqueda_cola.sv
// Two-entry FIFO of {pc, instr} pairs sitting at the IF/ID boundary.
module cola_instrucciones #(
    parameter int ANCHO_PC    = 11,
    parameter int ANCHO_INSTR = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [ANCHO_PC-1:0]    push_pc,
    input  logic [ANCHO_INSTR-1:0] push_instr,
    output logic [ANCHO_PC-1:0]    head_pc,
    output logic [ANCHO_INSTR-1:0] head_instr,
    output logic                   valid,
    output logic [1:0]             occupancy
);

    logic [ANCHO_PC-1:0]    pc_q    [2];
    logic [ANCHO_PC-1:0]    pc_d    [2];
    logic [ANCHO_INSTR-1:0] instr_q [2];
    logic [ANCHO_INSTR-1:0] instr_d [2];
    logic                   rd_q, rd_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   wr_idx;

    // The tail slot is the head slot offset by the current count.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        wr_idx  = rd_q ^ cnt_q[0];
        if (flush) begin
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) begin
                pc_d[wr_idx]    = push_pc;
                instr_d[wr_idx] = push_instr;
            end
            if (pop) begin
                rd_d = ~rd_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '{default: '0};
            instr_q <= '{default: '0};
            rd_q    <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head_pc    = pc_q[rd_q];
    assign head_instr = instr_q[rd_q];
    assign valid      = (cnt_q != 2'd0);
    assign occupancy  = cnt_q;

    no_desborde: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && !flush && cnt_q == 2'd2));

endmodule

// File: rtl/control_busqueda.sv
// Instruction-fetch controller: drives the PC register, reads instruction memory
// over req/ack and queues fetched words for decode, dropping wrong-path data.
module control_busqueda
    import control_busqueda_pkg::*;
#(
    parameter int                  ANCHO_PC    = ANCHO_PC_DEF,
    parameter int                  ANCHO_INSTR = ANCHO_INSTR_DEF,
    parameter logic [ANCHO_PC-1:0] PC_INICIAL  = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ANCHO_PC-1:0]    pc_actual,
    output logic [ANCHO_PC-1:0]    siguiente_pc,
    output logic                   enable_pc,
    output logic                   mem_req,
    output logic [ANCHO_PC-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [ANCHO_INSTR-1:0] mem_dato,
    input  logic                   stall,
    input  logic                   salto_tomado,
    input  logic [ANCHO_PC-1:0]    direccion_salto,
    output logic [ANCHO_INSTR-1:0] instr,
    output logic [ANCHO_PC-1:0]    pc_instr,
    output logic                   instr_valida
);

    estado_t             estado_q, estado_d;
    logic [ANCHO_PC-1:0] mem_addr_q, mem_addr_d;
    logic                carga_pc;
    logic [ANCHO_PC-1:0] pc_siguiente_c;
    logic                push, pop, flush;
    logic [1:0]          ocupacion;

    // A redirect always wins the PC mux and empties the queue; the FSM only
    // decides where the outstanding request (if any) ends up.
    always_comb begin
        estado_d       = estado_q;
        mem_addr_d     = mem_addr_q;
        carga_pc       = 1'b0;
        pc_siguiente_c = '0;
        push           = 1'b0;
        flush          = salto_tomado;
        if (salto_tomado) begin
            carga_pc       = 1'b1;
            pc_siguiente_c = direccion_salto;
        end
        case (estado_q)
            INICIO: begin
                carga_pc = 1'b1;
                if (!salto_tomado) begin
                    pc_siguiente_c = PC_INICIAL;
                end
                estado_d = BUSCAR;
            end
            BUSCAR: begin
                if (!salto_tomado && ocupacion <= 2'd1) begin
                    mem_addr_d = pc_actual;
                    estado_d   = ESPERAR;
                end
            end
            ESPERAR: begin
                if (salto_tomado) begin
                    estado_d = mem_ack ? BUSCAR : DESCARTAR;
                end else if (mem_ack) begin
                    push           = 1'b1;
                    carga_pc       = 1'b1;
                    pc_siguiente_c = mem_addr_q + 1'b1;
                    estado_d       = BUSCAR;
                end
            end
            DESCARTAR: begin
                if (mem_ack) begin
                    estado_d = BUSCAR;
                end
            end
            default: estado_d = INICIO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= INICIO;
            mem_addr_q <= '0;
        end else begin
            estado_q   <= estado_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // PC strobe must stay quiet while reset is held even though the state reads INICIO.
    assign enable_pc    = reset_n & carga_pc;
    assign siguiente_pc = reset_n ? pc_siguiente_c : '0;
    assign mem_req      = (estado_q == ESPERAR) || (estado_q == DESCARTAR);
    assign mem_addr     = mem_addr_q;
    assign pop          = instr_valida && !stall && !salto_tomado;

    cola_instrucciones #(
        .ANCHO_PC    (ANCHO_PC),
        .ANCHO_INSTR (ANCHO_INSTR)
    ) u_cola (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_pc    (mem_addr_q),
        .push_instr (mem_dato),
        .head_pc    (pc_instr),
        .head_instr (instr),
        .valid      (instr_valida),
        .occupancy  (ocupacion)
    );

endmodule

// File: tb/tb_control_busqueda.sv
// Bench for control_busqueda: directed fetch scenarios, then random stall/redirect/latency
// traffic checked against a fetch-stream reference model.
module tb_control_busqueda;

    localparam int AP = 11;
    localparam int AI = 32;
    localparam logic [AP-1:0] PC0 = 11'h000;
    localparam logic [AP-1:0] PC1 = 11'h7FF;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // DUT with PC_INICIAL = 0, variable-latency memory
    logic [AP-1:0] pc_reg = '0;
    logic [AP-1:0] siguiente_pc, mem_addr, direccion_salto, pc_instr;
    logic          enable_pc, mem_req, instr_valida;
    logic          mem_ack = 1'b0;
    logic          stall = 1'b0, salto_tomado = 1'b0;
    logic [AI-1:0] mem_dato, instr;

    // DUT with PC_INICIAL = 0x7FF, zero-wait memory
    logic [AP-1:0] pc_reg_b = '0;
    logic [AP-1:0] siguiente_pc_b, mem_addr_b, pc_instr_b;
    logic          enable_pc_b, mem_req_b, mem_ack_b, instr_valida_b;
    logic          stall_b = 1'b1;
    logic [AI-1:0] mem_dato_b, instr_b;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    function automatic logic [AI-1:0] palabra(input logic [AP-1:0] a);
        return ({21'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    control_busqueda #(.ANCHO_PC(AP), .ANCHO_INSTR(AI), .PC_INICIAL(PC0)) dut (
        .clock(clock), .reset_n(reset_n), .pc_actual(pc_reg),
        .siguiente_pc(siguiente_pc), .enable_pc(enable_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_dato(mem_dato),
        .stall(stall), .salto_tomado(salto_tomado), .direccion_salto(direccion_salto),
        .instr(instr), .pc_instr(pc_instr), .instr_valida(instr_valida)
    );

    control_busqueda #(.ANCHO_PC(AP), .ANCHO_INSTR(AI), .PC_INICIAL(PC1)) dut_b (
        .clock(clock), .reset_n(reset_n), .pc_actual(pc_reg_b),
        .siguiente_pc(siguiente_pc_b), .enable_pc(enable_pc_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack_b), .mem_dato(mem_dato_b),
        .stall(stall_b), .salto_tomado(1'b0), .direccion_salto(11'h000),
        .instr(instr_b), .pc_instr(pc_instr_b), .instr_valida(instr_valida_b)
    );

    // Environment: PC registers and memories
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc_reg <= '0;
        else if (enable_pc) pc_reg <= siguiente_pc;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) pc_reg_b <= '0;
        else if (enable_pc_b) pc_reg_b <= siguiente_pc_b;
    end

    int lat = 1;
    int ciclos_req = 0;
    always begin
        @(posedge clock);
        #1;
        if (mem_req) ciclos_req++;
        else ciclos_req = 0;
        mem_ack = mem_req && (ciclos_req >= lat);
    end
    assign mem_dato   = palabra(mem_addr);
    assign mem_ack_b  = mem_req_b;
    assign mem_dato_b = palabra(mem_addr_b);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] req);
        compared++;
        assert (obs === req) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    // Reference model: the delivered stream must be consecutive word addresses starting at
    // PC_INICIAL or at the latest redirect target; every request launches from the fetch pointer.
    logic [AP-1:0] exp_next = PC0;
    logic [AP-1:0] exp_fetch = PC0;
    logic [AP-1:0] exp_sig;
    int   ocup = 0;
    int   n_pops = 0;
    bit   desc = 1'b0, rst_prev = 1'b1, req_prev = 1'b0;
    bit   primer, m_push, m_pop, exp_en;

    always @(negedge clock) begin
        if (!reset_n) begin
            check_output("sb_rst_en", enable_pc, 0);
            check_output("sb_rst_req", mem_req, 0);
            exp_next = PC0; exp_fetch = PC0; ocup = 0;
            desc = 1'b0; rst_prev = 1'b1; req_prev = 1'b0;
        end else begin
            primer   = rst_prev;
            rst_prev = 1'b0;
            m_push   = !primer && mem_req && mem_ack && !salto_tomado && !desc;
            m_pop    = (ocup > 0) && !stall && !salto_tomado;
            exp_en   = 1'b1;
            exp_sig  = '0;
            if (salto_tomado) exp_sig = direccion_salto;
            else if (primer) exp_sig = PC0;
            else if (m_push) exp_sig = exp_fetch + 11'd1;
            else exp_en = 1'b0;

            check_output("sb_enable_pc", enable_pc, exp_en);
            if (exp_en) check_output("sb_siguiente_pc", siguiente_pc, exp_sig);
            check_output("sb_instr_valida", instr_valida, ocup > 0);
            if (m_pop) begin
                check_output("sb_pc_instr", pc_instr, exp_next);
                check_output("sb_instr", instr, palabra(exp_next));
                exp_next = exp_next + 11'd1;
                n_pops++;
            end
            if (mem_req && !req_prev) check_output("sb_mem_addr", mem_addr, exp_fetch);

            if (salto_tomado) begin
                ocup = 0; exp_next = direccion_salto; exp_fetch = direccion_salto;
                desc = mem_req && !mem_ack;
            end else begin
                if (m_push) begin ocup++; exp_fetch = exp_fetch + 11'd1; end
                if (m_pop) ocup--;
                if (mem_req && mem_ack) desc = 1'b0;
            end
            req_prev = mem_req;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_launch(input string tag, input logic [AP-1:0] dir_esp);
        int k;
        k = 0;
        while (mem_req && k < 50) begin tick(); k++; end
        while (!mem_req && k < 100) begin tick(); k++; end
        check_output({tag, "_req"}, mem_req, 1);
        check_output(tag, mem_addr, dir_esp);
    endtask

    initial begin
        int k;
        direccion_salto = '0;
        tick(2);
        // reset values
        check_output("rst_instr_valida", instr_valida, 0);
        check_output("rst_instr", instr, 0);
        check_output("rst_pc_instr", pc_instr, 0);
        check_output("rst_mem_req", mem_req, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_enable_pc", enable_pc, 0);
        check_output("rst_siguiente_pc", siguiente_pc, 0);

        // 1: free-running fetch 0,1,2,3...
        reset_n = 1'b1;
        tick(16);
        check_output("t1_pops", n_pops >= 4, 1);

        // 2: decode stalled from the start
        reset_n = 1'b0; stall = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        check_output("t2_valida", instr_valida, 1);
        check_output("t2_mem_req", mem_req, 0);
        check_output("t2_pc_actual", pc_reg, 2);
        check_output("t2_head0", pc_instr, 0);
        stall = 1'b0;
        tick();
        check_output("t2_head1", pc_instr, 1);
        wait_launch("t2_resume", 11'd2);

        // 3: redirect while idle with a full queue
        stall = 1'b1;
        tick(10);
        check_output("t3_full_valida", instr_valida, 1);
        check_output("t3_full_req", mem_req, 0);
        salto_tomado = 1'b1; direccion_salto = 11'h100;
        tick();
        salto_tomado = 1'b0;
        check_output("t3_flushed", instr_valida, 0);
        wait_launch("t3_launch0", 11'h100);
        wait_launch("t3_launch1", 11'h101);

        // 4: redirect in the first wait cycle of a 3-cycle read
        stall = 1'b0; lat = 3; reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check_output("t4_req", mem_req, 1);
        salto_tomado = 1'b1; direccion_salto = 11'h100;
        #1;
        check_output("t4_siguiente_pc", siguiente_pc, 11'h100);
        tick();
        salto_tomado = 1'b0;
        check_output("t4_pc_actual", pc_reg, 11'h100);
        tick(2);
        check_output("t4_no_push", instr_valida, 0);
        check_output("t4_pc_hold", pc_reg, 11'h100);
        wait_launch("t4_launch", 11'h100);

        // 5: redirect coinciding with the ack for address 5
        lat = 2; reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        k = 0;
        while (!(mem_req && mem_ack && mem_addr == 11'd5) && k < 80) begin tick(); k++; end
        check_output("t5_ack", mem_ack, 1);
        check_output("t5_addr", mem_addr, 5);
        salto_tomado = 1'b1; direccion_salto = 11'h040;
        #1;
        check_output("t5_enable_pc", enable_pc, 1);
        check_output("t5_siguiente_pc", siguiente_pc, 11'h040);
        tick();
        salto_tomado = 1'b0;
        wait_launch("t5_launch", 11'h040);

        // 6: PC_INICIAL = 0x7FF wraps, then reset mid-request
        stall_b = 1'b1; reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(8);
        check_output("t6_valida", instr_valida_b, 1);
        check_output("t6_head0", pc_instr_b, 11'h7FF);
        check_output("t6_instr0", instr_b, palabra(11'h7FF));
        check_output("t6_req_idle", mem_req_b, 0);
        check_output("t6_pc_actual", pc_reg_b, 11'h001);
        stall_b = 1'b0;
        tick();
        stall_b = 1'b1;
        check_output("t6_head1", pc_instr_b, 11'h000);
        check_output("t6_instr1", instr_b, palabra(11'h000));
        stall_b = 1'b0;
        k = 0;
        while (!mem_req_b && k < 20) begin tick(); k++; end
        check_output("t6_req_high", mem_req_b, 1);
        reset_n = 1'b0;
        #1;
        check_output("t6_rst_req", mem_req_b, 0);
        check_output("t6_rst_enable", enable_pc_b, 0);
        check_output("t6_rst_siguiente", siguiente_pc_b, 0);
        check_output("t6_rst_valida", instr_valida_b, 0);
        tick(2);
        reset_n = 1'b1;
        #1;
        check_output("t6_init_enable", enable_pc_b, 1);
        check_output("t6_init_siguiente", siguiente_pc_b, 11'h7FF);

        // randomized stall / redirect / latency traffic
        k = n_pops;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        repeat (3000) begin
            stall           = ($urandom_range(0, 3) == 0);
            salto_tomado    = ($urandom_range(0, 11) == 0);
            direccion_salto = AP'($urandom);
            lat             = $urandom_range(1, 4);
            tick();
        end
        salto_tomado = 1'b0; stall = 1'b0;
        tick(5);
        check_output("rnd_progress", (n_pops - k) > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
